// File: rtl/exc_pkg.sv
// Shared types and syndrome encoding for the LEGv8 exception unit.
package exc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TAKE,
        HANDLER,
        RETURN,
        HALT
    } exc_state_e;

    localparam int unsigned ES_NONE    = 0;
    localparam int unsigned ES_INVALID = 2;
    localparam int unsigned ES_DFAULT  = 3;

    // IRQ syndrome is {1'b1, k} with the marker bit at the top of a w-bit code.
    function automatic int unsigned es_irq(input int unsigned k, input int unsigned w);
        return (32'd1 << (w - 1)) | k;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the pending, unacknowledged IRQ lines.
module irq_prio_enc #(
    parameter int N_IRQ = 4,
    parameter int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic [N_IRQ-1:0] req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (req[k]) idx = IDX_W'(k);
        end
    end

endmodule

// File: rtl/exception_unit.sv
// Exception/interrupt controller: arbitrates invalid-opcode vs. IRQs, captures
// syndrome and return PC, sequences ERET and latches double faults.
module exception_unit
    import exc_pkg::*;
#(
    parameter int N_IRQ     = 4,
    parameter int ESTATUS_W = 4,
    parameter int PC_W      = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_IRQ-1:0]     irq,
    input  logic [N_IRQ-1:0]     irq_en,
    input  logic                 not_an_instr,
    input  logic                 is_eret,
    input  logic [PC_W-1:0]      pc_cur,
    output logic                 exc,
    output logic                 eret,
    output logic [ESTATUS_W-1:0] estatus,
    output logic [PC_W-1:0]      elr,
    output logic [N_IRQ-1:0]     irq_ack,
    output logic                 in_handler,
    output logic                 halted
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    exc_state_e        state;
    logic [N_IRQ-1:0]  req;
    logic              irq_valid;
    logic [IDX_W-1:0]  irq_idx;
    logic [N_IRQ-1:0]  ack_set;

    assign req = irq & irq_en & ~irq_ack;

    irq_prio_enc #(
        .N_IRQ (N_IRQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .req   (req),
        .valid (irq_valid),
        .idx   (irq_idx)
    );

    // An IRQ is only acknowledged when it actually wins arbitration in IDLE.
    always_comb begin
        ack_set = '0;
        if (state == IDLE && !not_an_instr && irq_valid) ack_set[irq_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            exc        <= 1'b0;
            eret       <= 1'b0;
            estatus    <= '0;
            elr        <= '0;
            irq_ack    <= '0;
            in_handler <= 1'b0;
            halted     <= 1'b0;
        end else begin
            // Four-phase handshake: ack drops once its request is seen low.
            irq_ack <= (irq_ack & irq) | ack_set;
            exc     <= 1'b0;
            eret    <= 1'b0;
            case (state)
                IDLE: begin
                    if (not_an_instr) begin
                        state      <= TAKE;
                        exc        <= 1'b1;
                        in_handler <= 1'b1;
                        estatus    <= ESTATUS_W'(ES_INVALID);
                        elr        <= pc_cur;
                    end else if (irq_valid) begin
                        state      <= TAKE;
                        exc        <= 1'b1;
                        in_handler <= 1'b1;
                        estatus    <= ESTATUS_W'(es_irq(32'(irq_idx), ESTATUS_W));
                        elr        <= pc_cur;
                    end
                end
                TAKE: state <= HANDLER;
                HANDLER: begin
                    if (is_eret) begin
                        state <= RETURN;
                        eret  <= 1'b1;
                    end else if (not_an_instr) begin
                        state      <= HALT;
                        in_handler <= 1'b0;
                        halted     <= 1'b1;
                        estatus    <= ESTATUS_W'(ES_DFAULT);
                    end
                end
                RETURN: begin
                    state      <= IDLE;
                    in_handler <= 1'b0;
                end
                HALT: state <= HALT;
                default: begin
                    state      <= IDLE;
                    in_handler <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/exception_unit.md
# exception_unit

Parametrised exception and interrupt controller for the single-cycle/pipelined LEGv8 core. It sits beside the main decoder. It arbitrates a synchronous invalid-opcode fault against `N_IRQ` maskable external interrupt lines and captures the exception syndrome and return PC. It drives a one-cycle exception redirect, runs a four-phase acknowledge per IRQ line, and sequences the return on ERET. Unlike a flat combinational exception flag, it keeps handler state, blocks nesting, and detects double faults.

## Interface
Parameters:
- `N_IRQ`, 4: number of external interrupt lines; 1..2^(ESTATUS_W-1).
- `ESTATUS_W`, 4: width of the syndrome code.
- `PC_W`, 64: width of the captured return address.

Ports:
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: reset, synchronous, active-high.
- `irq`, in, N_IRQ: level-sensitive interrupt requests.
- `irq_en`, in, N_IRQ: per-line enable mask.
- `not_an_instr`, in, 1: decoder flags the current instruction as invalid.
- `is_eret`, in, 1: decoder flags the current instruction as ERET.
- `pc_cur`, in, PC_W: PC of the current instruction.
- `exc`, out, 1: one-cycle redirect/flush pulse to the exception vector.
- `eret`, out, 1: one-cycle return pulse; PC source = `elr`.
- `estatus`, out, ESTATUS_W: syndrome of the last taken exception.
- `elr`, out, PC_W: captured return PC.
- `irq_ack`, out, N_IRQ: per-line acknowledge.
- `in_handler`, out, 1: high while an exception is being serviced.
- `halted`, out, 1: double fault; sticky until reset.

## Operation
- FSM states and transitions:
  - IDLE: on a trigger -> TAKE.
  - TAKE: always -> HANDLER.
  - HANDLER: `is_eret` -> RETURN; `not_an_instr` -> HALT.
  - RETURN: always -> IDLE.
  - HALT: stays in HALT until reset.
- Trigger in IDLE: `not_an_instr`, or any `irq[k] & irq_en[k] & ~irq_ack[k]`.
- Priority: invalid opcode beats any IRQ; among IRQs, the lowest index wins.
- Syndrome codes:
  - 0: none.
  - 2: invalid opcode.
  - 3: double fault.
  - IRQ k: {1'b1, k} zero-extended to ESTATUS_W (e.g. IRQ2 = 4'b1010).
- On IDLE->TAKE, register in the same edge:
  - `estatus` = winning code.
  - `elr` = `pc_cur` of the detection cycle.
  - For IRQ k only: set `irq_ack[k]`.
- `irq_ack[k]` stays high until `irq[k]` is sampled low, then clears on the next edge (four-phase). This runs independently of the FSM and may outlive the handler.
- While `irq_ack[k]` is high, line k cannot be retaken.
- IRQs arriving during TAKE/HANDLER/RETURN stay pending; nothing is latched. A request that drops before IDLE is lost.
- HANDLER with `is_eret` and `not_an_instr` both high: ERET wins.
- HANDLER with `not_an_instr` alone: `estatus` = 3, `halted` = 1. `elr` is unchanged and `exc` is not pulsed.
- `is_eret` outside HANDLER is ignored: no `eret` pulse.
- `in_handler` = state in {TAKE, HANDLER, RETURN}.

## Timing
- Reset values: all outputs 0 and state IDLE.
- A reset mid-operation also clears `irq_ack` and `halted` on the same edge.
- Exception latency is 1 cycle: a trigger at edge n gives `exc` = 1 during cycle n+1 (TAKE), with `estatus`/`elr` already valid.
- `eret` is high for exactly the one RETURN cycle after `is_eret` is sampled.
- Earliest re-entry: the cycle after RETURN, with the trigger sampled in IDLE. Back-to-back exceptions are therefore 4 cycles apart minimum.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `exc_pkg`:
  - FSM state enum (IDLE, TAKE, HANDLER, RETURN, HALT).
  - Syndrome constants ES_NONE, ES_INVALID, ES_DFAULT.
  - Function `es_irq(k)`.
- Sub-module `irq_prio_enc`: parametrised lowest-index-first priority encoder. Outputs `valid` and `idx[$clog2(N_IRQ)]`. Input is `irq & irq_en & ~irq_ack`.

## Test plan
- Invalid opcode: `not_an_instr`=1, `pc_cur`=0x40 in IDLE. Expect `exc` pulse next cycle, `estatus`=2, `elr`=0x40, `irq_ack`=0.
- Contention: `irq`=4'b1100 and `not_an_instr`=1 together. Expect `estatus`=2. Then ERET; with `irq` still high, expect IRQ2 taken (`estatus`=4'b1010, `irq_ack`=4'b0100).
- Masking and handshake: `irq[1]`=1 with `irq_en[1]`=0. Expect no exception. Enable it: IRQ1 taken, `irq_ack[1]` held. ERET with `irq[1]` still high: no retake. Drop `irq[1]`: ack clears one cycle later.
- Double fault: `not_an_instr` in HANDLER. Expect `halted`=1 and `estatus`=3. Further IRQs and ERET are ignored until reset.
- Reset mid-handler: reset asserted in HANDLER with `irq_ack` high. Next cycle all outputs are 0 and state is IDLE.
- Stray ERET: `is_eret`=1 in IDLE. Expect no `eret` pulse and no state change.
